// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter that funnels N_CH byte-wide client channels onto one
// 16-bit SDRAM port using a toggle handshake. Each channel has a request slot, and each access has a timeout.
module sdram_req_arbiter #(
    parameter int N_CH    = 2,
    parameter int AW      = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_CH-1:0]     ch_cs,
    input  logic [N_CH-1:0]     ch_oe,
    input  logic [N_CH-1:0]     ch_we,
    input  logic [N_CH*AW-1:0]  ch_a,
    input  logic [N_CH*8-1:0]   ch_d,
    output logic [N_CH*8-1:0]   ch_q,
    output logic [N_CH-1:0]     ch_busy,
    output logic                mem_req,
    input  logic                mem_ack,
    output logic [AW-2:0]       mem_a,
    output logic [1:0]          mem_ds,
    output logic                mem_we,
    output logic [15:0]         mem_d,
    input  logic [15:0]         mem_q,
    output logic                timeout_err,
    output logic                dbg_state
);

    // Handshake: an access is outstanding while mem_req != mem_ack. The SDRAM side
    // completes it by making mem_ack equal to mem_req, and mem_q is valid in that same cycle.
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t          state, state_next;
    logic [N_CH-1:0] rd_now, wr_now, trig;
    logic [N_CH-1:0] prev_rd, prev_wr, pend, repend, slot_we;
    logic [AW-1:0]   prev_a [N_CH];
    logic [AW-1:0]   slot_a [N_CH];
    logic [7:0]      slot_d [N_CH];
    logic [CW-1:0]   rr_ptr, grant, pick;
    logic [CW:0]     sum;
    logic            pick_valid, cur_odd;
    logic [9:0]      cnt;
    logic            acked, do_grant, do_done, do_abort;

    assign acked     = (mem_ack == mem_req);
    assign dbg_state = (state == WAIT);

    always_comb begin
        rd_now  = '0;
        wr_now  = '0;
        trig    = '0;
        ch_busy = '0;
        for (int i = 0; i < N_CH; i++) begin
            rd_now[i]  = ch_cs[i] & ch_oe[i];
            wr_now[i]  = ch_cs[i] & ch_we[i];
            trig[i]    = (rd_now[i] & ~prev_rd[i]) | (wr_now[i] & ~prev_wr[i])
                       | (rd_now[i] & (ch_a[i*AW +: AW] != prev_a[i]));
            ch_busy[i] = pend[i] | ((state == WAIT) && (grant == CW'(i)));
        end
    end

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        sum        = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (sum >= (CW+1)'(N_CH)) sum = sum - (CW+1)'(N_CH);
            if (pend[sum[CW-1:0]]) begin
                pick       = sum[CW-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    // Issue is also gated on acked, so a timed-out access resynchronises the toggle pair first.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid && acked) begin
                    do_grant   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (acked) begin
                    do_done    = 1'b1;
                    state_next = IDLE;
                end else if (cnt == 10'(TIMEOUT - 1)) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_rd     <= '0;
            prev_wr     <= '0;
            pend        <= '0;
            repend      <= '0;
            slot_we     <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            cur_odd     <= 1'b0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_a       <= '0;
            mem_ds      <= '0;
            mem_we      <= 1'b0;
            mem_d       <= '0;
            ch_q        <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                prev_a[i] <= '0;
                slot_a[i] <= '0;
                slot_d[i] <= '0;
            end
        end else begin
            prev_rd <= rd_now;
            prev_wr <= wr_now;
            for (int i = 0; i < N_CH; i++) begin
                prev_a[i] <= ch_a[i*AW +: AW];
                if (trig[i]) begin
                    slot_a[i]  <= ch_a[i*AW +: AW];
                    slot_d[i]  <= ch_d[i*8 +: 8];
                    slot_we[i] <= wr_now[i] & ~rd_now[i];
                end
                // A channel being granted on this edge already counts as in flight.
                if (trig[i]) begin
                    pend[i]   <= 1'b1;
                    repend[i] <= (((state == WAIT) && (grant == CW'(i))) ||
                                  (do_grant && (pick == CW'(i))))
                               && !((do_done || do_abort) && (grant == CW'(i)));
                end else if ((do_done || do_abort) && (grant == CW'(i))) begin
                    pend[i]   <= do_done & repend[i];
                    repend[i] <= 1'b0;
                end
                if (do_done && !mem_we && (grant == CW'(i)))
                    ch_q[i*8 +: 8] <= cur_odd ? mem_q[15:8] : mem_q[7:0];
            end

            if (do_grant) begin
                grant   <= pick;
                rr_ptr  <= (pick == CW'(N_CH - 1)) ? '0 : pick + 1'b1;
                mem_req <= ~mem_req;
                mem_a   <= slot_a[pick][AW-1:1];
                cur_odd <= slot_a[pick][0];
                mem_we  <= slot_we[pick];
                mem_d   <= {slot_d[pick], slot_d[pick]};
                mem_ds  <= !slot_we[pick] ? 2'b11 : (slot_a[pick][0] ? 2'b10 : 2'b01);
                cnt     <= '0;
            end else if (state == WAIT && !do_done && !do_abort) begin
                cnt <= cnt + 10'd1;
            end

            if (do_abort) timeout_err <= 1'b1;
        end
    end

endmodule
